// File: rtl/logic_pkg.sv
// Shared definitions for the pipelined bitwise logic unit: operation
// codes and the legal ranges of the elaboration parameters.
package logic_pkg;

  typedef enum logic [2:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_XOR    = 3'd2,
    OP_NAND   = 3'd3,
    OP_NOR    = 3'd4,
    OP_XNOR   = 3'd5,
    OP_NOT_A  = 3'd6,
    OP_ACC_OR = 3'd7
  } op_e;

  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 4;
  localparam int WIDTH_MIN  = 1;
  localparam int WIDTH_MAX  = 64;

endpackage

// File: rtl/logic_op_core.sv
// Combinational heart of the logic unit: evaluates one of eight bitwise
// operations and derives the zero flag (and parity when
// LOGIC_UNIT_PARITY_EN is defined) from the result.
module logic_op_core
  import logic_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  input  logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] result,
  output logic             zero
`ifdef LOGIC_UNIT_PARITY_EN
  , output logic           parity
`endif
);

  // Select the operation; acc is already the post-clear accumulator value
  always_comb begin
    result = '0;
    case (op)
      OP_AND:    result = a & b;
      OP_OR:     result = a | b;
      OP_XOR:    result = a ^ b;
      OP_NAND:   result = ~(a & b);
      OP_NOR:    result = ~(a | b);
      OP_XNOR:   result = ~(a ^ b);
      OP_NOT_A:  result = ~a;
      OP_ACC_OR: result = acc | a | b;
      default:   result = '0;
    endcase
  end

  assign zero = ~|result;

`ifdef LOGIC_UNIT_PARITY_EN
  assign parity = ^result;
`endif

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic engine with a sticky OR accumulator.
// Result, zero flag and valid travel through STAGES register stages.
// Optional feature macro: LOGIC_UNIT_PARITY_EN adds o_parity.
module logic_unit_pipe
  import logic_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_data_a,
  input  logic [WIDTH-1:0] i_data_b,
  input  logic             i_acc_clr,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_zero
`ifdef LOGIC_UNIT_PARITY_EN
  , output logic           o_parity
`endif
);

  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("logic_unit_pipe: STAGES out of range");
  end
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("logic_unit_pipe: WIDTH out of range");
  end

  op_e              op;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_eff;
  logic [WIDTH-1:0] core_result;
  logic             core_zero;

  logic [STAGES-1:0] valid_q;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [STAGES-1:0] zero_q;

`ifdef LOGIC_UNIT_PARITY_EN
  logic              core_parity;
  logic [STAGES-1:0] parity_q;
`endif

  assign op      = op_e'(i_op);
  // A clear in the same cycle as an ACC_OR beat wins, so the beat sees zero
  assign acc_eff = i_acc_clr ? '0 : acc_q;

  logic_op_core #(.WIDTH(WIDTH)) u_core (
    .a      (i_data_a),
    .b      (i_data_b),
    .op     (op),
    .acc    (acc_eff),
    .result (core_result),
    .zero   (core_zero)
`ifdef LOGIC_UNIT_PARITY_EN
    , .parity (core_parity)
`endif
  );

  // Accumulator moves only on accepted ACC_OR beats or an explicit clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (i_valid && op == OP_ACC_OR) begin
      acc_q <= core_result;
    end else if (i_acc_clr) begin
      acc_q <= '0;
    end
  end

  // Valid shifts every cycle; payload of a stage loads only behind a valid beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      zero_q  <= '0;
`ifdef LOGIC_UNIT_PARITY_EN
      parity_q <= '0;
`endif
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q[0] <= i_valid;
      if (i_valid) begin
        data_q[0] <= core_result;
        zero_q[0] <= core_zero;
`ifdef LOGIC_UNIT_PARITY_EN
        parity_q[0] <= core_parity;
`endif
      end
      for (int k = 1; k < STAGES; k++) begin
        valid_q[k] <= valid_q[k-1];
        if (valid_q[k-1]) begin
          data_q[k] <= data_q[k-1];
          zero_q[k] <= zero_q[k-1];
`ifdef LOGIC_UNIT_PARITY_EN
          parity_q[k] <= parity_q[k-1];
`endif
        end
      end
    end
  end

  assign o_valid = valid_q[STAGES-1];
  assign o_data  = data_q[STAGES-1];
  assign o_zero  = zero_q[STAGES-1];
`ifdef LOGIC_UNIT_PARITY_EN
  assign o_parity = parity_q[STAGES-1];
`endif

endmodule
